// File: rtl/dmem_arb_pkg.sv
// Shared encodings and MEM_LAT limits for the data-memory arbiter.
// Optional round-robin arbitration is selected with DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  // True when lat fits the 4-bit access counter.
  function automatic logic mem_lat_ok(input int unsigned lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-memory arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_cs;
  logic              cpu_r;
  logic              cpu_w;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_cs;
  logic              mem_r;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way grant selector. CPU wins ties unless DMEM_ARB_RR_EN is defined,
// in which case a tie goes to the requester not granted last.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dma_req,
  input  owner_e last_grant,
  output owner_e grant
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    grant = OWN_CPU;
    if (cpu_req && dma_req) begin
      grant = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      grant = OWN_DMA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = OWN_CPU;
    if (dma_req && !cpu_req) begin
      grant = OWN_DMA;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU data port and a DMA port.
// Each transfer: one IDLE grant cycle, MEM_LAT BUSY cycles, one DONE cycle.
// Define DMEM_ARB_RR_EN for round-robin tie breaking (default: CPU priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_lat_check
    $error("dmem_arbiter: MEM_LAT must be in 1..15");
  end

  logic   cpu_req_c;
  owner_e grant_c;
  owner_e last_grant_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic              dma_ack_q, dma_ack_d;

  assign cpu_req_c = bus.cpu_cs & (bus.cpu_r | bus.cpu_w);

`ifdef DMEM_ARB_RR_EN
  owner_e last_q, last_d;
  assign last_grant_c = last_q;
`else
  assign last_grant_c = OWN_DMA;
`endif

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req_c),
    .dma_req    (bus.dma_req),
    .last_grant (last_grant_c),
    .grant      (grant_c)
  );

  // Next-state and registered-output logic; strobes follow the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    mem_cs_d  = 1'b0;
    mem_r_d   = 1'b0;
    mem_w_d   = 1'b0;
    dma_ack_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_d    = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_c || bus.dma_req) begin
          owner_d = grant_c;
          if (grant_c == OWN_CPU) begin
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            we_d    = bus.cpu_w;
          end else begin
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
            we_d    = bus.dma_we;
          end
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = ST_BUSY;
          mem_cs_d = 1'b1;
          mem_r_d  = ~we_d;
          mem_w_d  = we_d;
`ifdef DMEM_ARB_RR_EN
          last_d   = grant_c;
`endif
        end
      end

      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_cs_d = 1'b1;
          mem_r_d  = ~we_q;
          mem_w_d  = we_q;
        end else begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d   = ST_DONE;
          dma_ack_d = (owner_q == OWN_DMA);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_DMA;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      mem_cs_q  <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      dma_ack_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q    <= OWN_DMA;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      mem_cs_q  <= mem_cs_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      dma_ack_q <= dma_ack_d;
`ifdef DMEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Stall must drop in the CPU's own DONE cycle so the PC advances at its end.
  assign bus.cpu_stall = cpu_req_c & ~((state_q == ST_DONE) & (owner_q == OWN_CPU)) & ~rst;

  assign bus.cpu_rdata = rdata_q;
  assign bus.dma_rdata = rdata_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_r     = mem_r_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory controller that sits between the single-cycle CPU's data port and the single-port data memory. It shares that memory with a second requester: a DMA/loader port used for program load and debug readback. It sequences each access over a configurable number of memory cycles and holds the CPU with a stall signal while its access is pending. Each transfer gets exactly one grant, one timed memory access and one completion cycle.

## Interface

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- MEM_LAT, 2, memory access cycles per transfer; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_cs  in  1  CPU data-memory chip select.
- cpu_r  in  1  CPU read strobe.
- cpu_w  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU address (ALU result).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  load data; valid in the CPU completion cycle.
- cpu_stall  out  1  hold PC and register-file writes.
- dma_req  in  1  DMA request level.
- dma_we  in  1  DMA write (1) or read (0).
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data; valid while dma_ack=1.
- dma_ack  out  1  one-cycle completion pulse.
- mem_cs, mem_r, mem_w  out  1 each  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle.

## Operation

Requests:
- cpu_req = cpu_cs & (cpu_r | cpu_w). cpu_cs alone is not a request.
- Both requesters hold the request and its address/data until completion.

FSM states IDLE, BUSY, DONE. A down-counter cnt (4 bits) and an owner register (CPU/DMA) support it.

IDLE:
- No request: stay in IDLE.
- One or more requests: pick the owner.
- Latch address, wdata and direction into holding registers.
- Load cnt = MEM_LAT-1 and go to BUSY.

BUSY:
- Drive mem_cs=1, mem_r/mem_w from the latched direction, and mem_addr/mem_wdata from the holding registers.
- If cnt≠0: decrement cnt.
- If cnt=0: capture mem_rdata into rdata_q (reads only) and go to DONE.

DONE:
- All mem strobes are 0.
- cpu_rdata = dma_rdata = rdata_q.
- dma_ack=1 if the owner is DMA.
- Always return to IDLE; no grant is made in DONE.

Stall:
- cpu_stall = cpu_req & ~(state==DONE & owner==CPU) & ~rst.
- The logic is combinational, with no path from cpu_stall back to cpu_cs.

Arbitration, when both request in IDLE: CPU wins by default; see Configuration.

Write direction: writes use the same sequence as reads. rdata_q is left unchanged on writes.

DMA request timing: a DMA requester that keeps dma_req high in the cycle after dma_ack is presenting a new request.

## Timing

- Grant to completion: one IDLE cycle, then MEM_LAT BUSY cycles, then one DONE cycle.
- CPU access from an idle arbiter: cpu_stall is high for MEM_LAT+1 cycles. The CPU advances at the edge that ends DONE.
- CPU request arriving while a DMA transfer is in progress: the stall covers the remainder of the DMA transfer, plus that transfer's DONE cycle, plus the CPU's own MEM_LAT+1 cycles.
- mem_cs is high for exactly MEM_LAT consecutive cycles per transfer.
- With MEM_LAT=1, BUSY lasts one cycle.

Reset values:
- state=IDLE, cnt=0, owner=DMA, last-granted=DMA.
- mem_cs/mem_r/mem_w=0, mem_addr=0, mem_wdata=0.
- rdata_q=0, so cpu_rdata=0 and dma_rdata=0.
- dma_ack=0, cpu_stall=0.

Reset mid-transfer:
- The next cycle is IDLE with strobes low.
- The aborted transfer never acks.
- rdata_q is cleared.

## Configuration

Macro: DMEM_ARB_RR_EN.
- Defined: round-robin. On a tie in IDLE, grant the requester that was not granted last. The last-granted register updates on every grant.
- Undefined: fixed priority, CPU over DMA. The last-granted register is not implemented.

## Structure

Shared package/header `dmem_arb_pkg` holds:
- state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
- owner encodings OWN_CPU=1'b0, OWN_DMA=1'b1;
- MEM_LAT range check constants.

Sub-module `dmem_arb_pick`: combinational 2-way grant selector. Inputs are cpu_req, dma_req and last_grant; output is the grant owner. The round-robin path is under DMEM_ARB_RR_EN.

## Test plan

- MEM_LAT=2, CPU load at 0x10, memory returns 0xDEADBEEF → mem_cs/mem_r high 2 cycles with mem_addr=0x10; cpu_stall high 3 cycles; DONE cycle has cpu_stall=0 and cpu_rdata=0xDEADBEEF.
- CPU store of 0x12345678 to 0x20 → mem_w high 2 cycles with mem_addr=0x20 and mem_wdata=0x12345678; cpu_stall 3 cycles; cpu_rdata unchanged.
- DMA read of 0x40 starts (memory returns 0xA5A5A5A5), CPU load requested in its first BUSY cycle → dma_ack pulse with dma_rdata=0xA5A5A5A5; CPU granted in the following IDLE; CPU stall totals 6 cycles.
- CPU and DMA both request in the same IDLE cycle after reset → CPU granted first in both configurations; DMA granted in the IDLE that follows the CPU's DONE, provided the CPU is not requesting.
- CPU requests continuously while dma_req is held → macro undefined: DMA is never granted; macro defined: grants alternate CPU, DMA, CPU, and so on.
- rst asserted during the second BUSY cycle of a DMA read → next cycle IDLE with mem_cs=0, dma_ack never asserted, dma_rdata=0, cpu_stall=0 while rst is high.
